// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e    : operation encoding carried on md_op (MD_OP_W bits)
//   - md_state_e : sequencer state (IDLE / RUN)
//   - is_md_busy_op / is_mult_op : op classification helpers
package md_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_md_busy_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_core.sv
// md_core: combinational multiply/divide datapath.
// Ports:
//   i_op   : operation code (only MULT/MULTU/DIV/DIVU produce results)
//   i_a    : rs operand (dividend / multiplicand)
//   i_b    : rt operand (divisor / multiplier)
//   o_hi   : product upper half, or remainder
//   o_lo   : product lower half, or quotient
//   o_div0 : divide op with zero divisor (result must not be committed)
module md_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo,
  output logic               o_div0
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    w_prod_s;
  logic [PW-1:0]    w_prod_u;
  logic             w_is_signed_div;
  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_b_div;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  // The low 2*WIDTH bits of a product of sign-extended operands equal the
  // signed product, so one unsigned multiplier shape serves both cases.
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};

  // Signed division is done on magnitudes and the signs restored after:
  // quotient truncates toward zero, remainder takes the dividend's sign.
  // The most-negative / -1 case falls out naturally: magnitude quotient is
  // 2^(WIDTH-1), sign positive, which wraps to 0x80..0 with remainder 0.
  assign w_is_signed_div = (i_op == MD_DIV);
  assign w_b_zero        = (i_b == '0);
  assign w_a_neg         = w_is_signed_div & i_a[WIDTH-1];
  assign w_b_neg         = w_is_signed_div & i_b[WIDTH-1];
  assign w_a_mag         = w_a_neg ? -i_a : i_a;
  assign w_b_mag         = w_b_neg ? -i_b : i_b;
  // Substitute 1 for a zero divisor so the divider never sees X; the result
  // is discarded anyway via o_div0.
  assign w_b_div         = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_q_mag         = w_a_mag / w_b_div;
  assign w_r_mag         = w_a_mag % w_b_div;
  assign w_q             = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r             = w_a_neg ? -w_r_mag : w_r_mag;

  always_comb begin
    o_hi   = '0;
    o_lo   = '0;
    o_div0 = 1'b0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV, MD_DIVU: begin
        o_hi   = w_r;
        o_lo   = w_q;
        o_div0 = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with architectural HI/LO.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : E-stage instruction is a valid md_op this cycle
//   md_op      : operation code (md_pkg::md_op_e)
//   src_a/b    : forwarded rs / rt values
//   busy       : multi-cycle operation in flight
//   hi, lo     : architectural HI / LO
//   rd_out     : mfhi -> hi, mflo -> lo, otherwise 0 (combinational)
//   md_use_d   : D-stage instruction uses the unit
//   md_stall   : D-stage stall request
//   dbg_state  : current sequencer state
// Handshake: start is a one-cycle qualifier sampled at the rising edge; it
// is only legal while busy is low. md_stall holds the D-stage user off from
// the cycle the op is started until the cycle after busy falls, so the
// consumer's start never overlaps busy.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4   // 2**CNT_W must exceed both cycle counts
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   rd_out,
  input  logic               md_use_d,
  output logic               md_stall,
  output md_state_e          dbg_state
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic             r_pend_ok;   // cleared for divide-by-zero: skip commit

  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_div0;
  logic [CNT_W-1:0] w_load_cnt;

  md_core #(.WIDTH(WIDTH)) u_core (
    .i_op   (md_op),
    .i_a    (src_a),
    .i_b    (src_b),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo),
    .o_div0 (w_div0)
  );

  assign w_load_cnt = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  // The result is computed and captured at the start edge; the counter only
  // models the latency the pipeline must observe before HI/LO change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_md_busy_op(md_op)) begin
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_pend_ok <= ~w_div0;
              r_cnt     <= w_load_cnt;
              r_state   <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              r_hi <= src_a;
            end else if (md_op == MD_MTLO) begin
              r_lo <= src_a;
            end
          end
        end
        ST_RUN: begin
          // Any start seen here is illegal and deliberately ignored.
          if (r_cnt == CNT_W'(1)) begin
            if (r_pend_ok) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;
  assign md_stall  = md_use_d & (busy | (start & is_md_busy_op(md_op)));

  always_comb begin
    rd_out = '0;
    if (md_op == MD_MFHI)      rd_out = r_hi;
    else if (md_op == MD_MFLO) rd_out = r_lo;
  end

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       md_op;
  logic [W-1:0]     src_a;
  logic [W-1:0]     src_b;
  logic             busy;
  logic [W-1:0]     hi;
  logic [W-1:0]     lo;
  logic [W-1:0]     rd_out;
  logic             md_use_d;
  logic             md_stall;
  md_state_e        dbg_state;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .rd_out    (rd_out),
    .md_use_d  (md_use_d),
    .md_stall  (md_stall),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model using 64-bit host arithmetic.
  function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] hc,
                                           input logic [W-1:0] lc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = {hc, lc};
    case (op)
      MD_MULT:  p = sa * sb;
      MD_MULTU: p = ua * ub;
      MD_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      MD_DIVU: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        p  = {ur[31:0], uq[31:0]};
      end
      default: ;
    endcase
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    exp_q.delete();
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    if (is_md_busy_op(op)) begin
      e = model(op, a, b, m_hi, m_lo);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
    end else if (op == MD_MTHI) begin
      m_hi = a;
    end else if (op == MD_MTLO) begin
      m_lo = a;
    end
    @(posedge clk);
    #1 start = 1'b0;
    md_op = MD_NOP;
  endtask

  // Counts busy cycles (bounded), then compares HI/LO with the queue head.
  task automatic wait_done(input string tag, input int n_exp);
    int             cnt;
    logic [2*W-1:0] e;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n_exp));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
      check({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
    end
  endtask

  task automatic read_check(input string tag, input logic [3:0] op, input logic [W-1:0] exp);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    #1 check(tag, 64'(rd_out), 64'(exp));
    @(posedge clk);
    #1 start = 1'b0;
    md_op = MD_NOP;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = MD_NOP;
    src_a    = '0;
    src_b    = '0;
    md_use_d = 1'b0;

    do_reset();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("mult", NM);
    check("mult_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("multu", NM);
    check("multu_hi_const", 64'(hi), 64'h0000_0000_0000_0001);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div", ND);
    check("div_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);

    // Divide by zero leaves HI/LO untouched.
    do_reset();
    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_done("divu0", ND);
    check("divu0_hi_const", 64'(hi), 64'h1234);
    check("divu0_lo_const", 64'(lo), 64'h0);
    read_check("mfhi_after_div0", MD_MFHI, 32'h0000_1234);

    // Signed overflow.
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", ND);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);

    // mtlo / readback / nop select.
    issue(MD_MTLO, 32'hCAFE_0001, 32'h0);
    read_check("mflo_mtlo", MD_MFLO, 32'hCAFE_0001);
    read_check("rd_nop", MD_NOP, 32'h0);

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) issue(MD_MTHI, $urandom, 32'h0);
      issue(op, a, b);
      wait_done($sformatf("rnd%0d_op%0d", i, op), is_mult_op(op) ? NM : ND);
    end

    // md_stall window around a mult.
    read_check("stall_idle_mfhi_lo", MD_MFHI, m_hi);
    @(negedge clk);
    md_use_d = 1'b1;
    start    = 1'b1;
    md_op    = MD_MFHI;
    #1 check("stall_mfhi_idle", 64'(md_stall), 64'(0));
    md_op    = MD_MULT;
    src_a    = 32'd12345;
    src_b    = 32'hFFFF_FFF0;
    exp_q.push_back(model(MD_MULT, 32'd12345, 32'hFFFF_FFF0, m_hi, m_lo));
    {m_hi, m_lo} = model(MD_MULT, 32'd12345, 32'hFFFF_FFF0, m_hi, m_lo);
    #1 check("stall_t0", 64'(md_stall), 64'(1));
    @(posedge clk);
    #1 start = 1'b0;
    md_op = MD_NOP;
    for (int k = 1; k <= NM; k++) begin
      @(negedge clk);
      check($sformatf("stall_t%0d", k), 64'(md_stall), 64'(1));
    end
    @(negedge clk);
    check("stall_release", 64'(md_stall), 64'(0));
    check("stall_busy_low", 64'(busy), 64'(0));
    md_use_d = 1'b0;
    if (exp_q.size() != 0) begin
      check("stall_lo", 64'(lo), 64'(exp_q[0][W-1:0]));
      check("stall_hi", 64'(hi), 64'(exp_q[0][2*W-1:W]));
      exp_q.delete();
    end
    read_check("mflo_after_stall", MD_MFLO, m_lo);

    // Reset during busy cycle 4 aborts the divide.
    @(negedge clk);
    start = 1'b1;
    md_op = MD_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    md_op = MD_NOP;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_busy%0d", k), 64'(busy), 64'(1));
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("abort_busy_low", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(m_hi));
    check("abort_lo", 64'(lo), 64'(m_lo));
    repeat (12) @(negedge clk);
    check("abort_no_commit_hi", 64'(hi), 64'(m_hi));
    check("abort_no_commit_lo", 64'(lo), 64'(m_lo));
    check("abort_still_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
